telemetry_sync_fifo: RTL and testbench

TELEMETRY_SYNC_FIFO -- requirements
Module: telemetry_sync_fifo

---
 rtl/telemetry_sync_fifo.sv | 128 ++++++++++++
 tb/tb_telemetry_sync_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_sync_fifo.sv
// Synchronous FIFO with registered occupancy/threshold flags, sticky error flags and a reset-busy window.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered standard-mode dout.
module telemetry_sync_fifo #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 10,
    parameter int PROG_FULL_TH  = 1000,
    parameter int PROG_EMPTY_TH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              prog_full,
    output logic              prog_empty,
    output logic [ADDR_W:0]   data_count,
    output logic              overflow,
    output logic              underflow,
    output logic              rst_busy
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PF_TH   = (ADDR_W+1)'(PROG_FULL_TH);
    localparam logic [ADDR_W:0] PE_TH   = (ADDR_W+1)'(PROG_EMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic            full_q, full_d, empty_q, empty_d;
    logic            prog_full_q, prog_full_d, prog_empty_q, prog_empty_d;
    logic            overflow_q, overflow_d, underflow_q, underflow_d;
    logic            rst_busy_q, rst_busy_d;
    logic [1:0]      rst_cnt_q, rst_cnt_d;
    logic            wr_acc, rd_acc;

    // Accept decisions use the pre-edge flags only.
    assign wr_acc = wr_en && !full_q && !rst_busy_q;
    assign rd_acc = rd_en && !empty_q && !rst_busy_q;

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= din;
    end

    always_comb begin
        rst_busy_d = rst_busy_q;
        rst_cnt_d  = rst_cnt_q;
        // Busy holds through two released edges and drops on the third.
        if (rst_busy_q) begin
            if (rst_cnt_q == 2'd2) rst_busy_d = 1'b0;
            else                   rst_cnt_d  = rst_cnt_q + 2'd1;
        end

        wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(wr_acc);
        rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(rd_acc);
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d       = rst_busy_d || (count_d == DEPTH_C);
        empty_d      = (count_d == '0);
        prog_full_d  = (count_d >= PF_TH);
        prog_empty_d = (count_d <= PE_TH);
        overflow_d   = overflow_q  || (wr_en && full_q  && !rst_busy_q);
        underflow_d  = underflow_q || (rd_en && empty_q && !rst_busy_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b1;
            empty_q      <= 1'b1;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            rst_busy_q   <= 1'b1;
            rst_cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            rst_busy_q   <= rst_busy_d;
            rst_cnt_q    <= rst_cnt_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented straight from storage; only meaningful while empty=0.
    assign dout = mem[rd_ptr_q[ADDR_W-1:0]];
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem[rd_ptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    assign dout = dout_q;
`endif

    assign full       = full_q;
    assign empty      = empty_q;
    assign prog_full  = prog_full_q;
    assign prog_empty = prog_empty_q;
    assign data_count = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign rst_busy   = rst_busy_q;
endmodule

// File: tb/tb_telemetry_sync_fifo.sv
// Directed bench for telemetry_sync_fifo at default parameters; follows FIFO_FWFT_EN for the output timing.
module tb_telemetry_sync_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] din = '0;
    logic        rd_en = 1'b0;
    logic [31:0] dout;
    logic        full, empty, prog_full, prog_empty;
    logic [10:0] data_count;
    logic        overflow, underflow, rst_busy;

    int n_cmp = 0;
    int n_bad = 0;

    telemetry_sync_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .prog_full  (prog_full),
        .prog_empty (prog_empty),
        .data_count (data_count),
        .overflow   (overflow),
        .underflow  (underflow),
        .rst_busy   (rst_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic push(input logic [31:0] d);
        wr_en = 1'b1;
        din   = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
        rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
        chk(tag, 64'(dout), 64'(exp));
        tick();
`else
        tick();
        chk(tag, 64'(dout), 64'(exp));
`endif
        rd_en = 1'b0;
    endtask

    task automatic pushpop(input logic [31:0] d, input logic [31:0] exp);
        wr_en = 1'b1;
        din   = d;
        pop("simul_dout", exp);
        wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] v;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy",      64'(rst_busy),   64'd1);
        chk("rst_full",      64'(full),       64'd1);
        chk("rst_empty",     64'(empty),      64'd1);
        chk("rst_prog_empty",64'(prog_empty), 64'd1);
        chk("rst_prog_full", 64'(prog_full),  64'd0);
        chk("rst_count",     64'(data_count), 64'd0);
        chk("rst_ovf",       64'(overflow),   64'd0);
        chk("rst_unf",       64'(underflow),  64'd0);
        chk("rst_dout",      64'(dout),       64'd0);

        // Release with a write held during the busy window
        rst_n = 1'b1;
        wr_en = 1'b1;
        din   = 32'd99;
        tick();
        chk("busy_e1", 64'(rst_busy), 64'd1);
        chk("full_e1", 64'(full),     64'd1);
        tick();
        chk("busy_e2", 64'(rst_busy), 64'd1);
        chk("full_e2", 64'(full),     64'd1);
        wr_en = 1'b0;
        tick();
        chk("busy_e3",  64'(rst_busy),   64'd0);
        chk("full_e3",  64'(full),       64'd0);
        chk("count_e3", 64'(data_count), 64'd0);
        chk("empty_e3", 64'(empty),      64'd1);
        chk("ovf_busy", 64'(overflow),   64'd0);

        // Fill
        for (int k = 0; k < 1024; k++) begin
            push(32'(k));
            chk("fill_count", 64'(data_count), 64'(k + 1));
            if (k == 7 || k == 8)     chk("fill_prog_empty", 64'(prog_empty), 64'(k == 7));
            if (k == 998 || k == 999) chk("fill_prog_full",  64'(prog_full),  64'(k == 999));
            if (k == 1022 || k == 1023) chk("fill_full", 64'(full), 64'(k == 1023));
        end
        push(32'd5555);
        chk("ovf_set",   64'(overflow),   64'd1);
        chk("ovf_count", 64'(data_count), 64'd1024);
        chk("ovf_full",  64'(full),       64'd1);

        // Drain
        for (int k = 0; k < 1024; k++) pop("drain_dout", 32'(k));
        chk("drain_empty", 64'(empty),      64'd1);
        chk("drain_count", 64'(data_count), 64'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("unf_set", 64'(underflow), 64'd1);
`ifndef FIFO_FWFT_EN
        chk("unf_dout_hold", 64'(dout), 64'd1023);
`endif
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Mid-operation reset discards contents and clears sticky flags
        push(32'd1);
        push(32'd2);
        push(32'd3);
        reset_dut();
        chk("mid_rst_count", 64'(data_count), 64'd0);
        chk("mid_rst_empty", 64'(empty),      64'd1);
        chk("mid_rst_ovf",   64'(overflow),   64'd0);
        chk("mid_rst_unf",   64'(underflow),  64'd0);

        // Simultaneous read/write at count 5
        for (int k = 0; k < 5; k++) push(32'(10 + k));
        chk("simul_count0", 64'(data_count), 64'd5);
        for (int k = 0; k < 10; k++) begin
            pushpop(32'(15 + k), 32'(10 + k));
            chk("simul_count", 64'(data_count), 64'd5);
        end
        for (int k = 0; k < 5; k++) pop("simul_tail", 32'(20 + k));
        chk("simul_empty", 64'(empty), 64'd1);

        // Both at count 0: write only, read flagged
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 32'd77;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("both0_count", 64'(data_count), 64'd1);
        chk("both0_unf",   64'(underflow),  64'd1);
        chk("both0_empty", 64'(empty),      64'd0);
        pop("both0_dout", 32'd77);

        // Wrap-around rounds
        reset_dut();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 700; i++) begin
                v = 32'd1234598765 + 32'(r * 700 + i);
                push(v);
            end
            chk("wrap_count_full", 64'(data_count), 64'd700);
            for (int i = 0; i < 700; i++) begin
                v = 32'd1234598765 + 32'(r * 700 + i);
                pop("wrap_dout", v);
            end
            chk("wrap_count_zero", 64'(data_count), 64'd0);
            chk("wrap_empty",      64'(empty),      64'd1);
        end

        // Mode check
        push(32'd1232468965);
        chk("mode_empty", 64'(empty), 64'd0);
`ifdef FIFO_FWFT_EN
        chk("mode_fwft_head", 64'(dout), 64'd1232468965);
`endif
        pop("mode_dout", 32'd1232468965);
        chk("mode_empty_after", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
